// File: rtl/ex4s_pkg.sv
// Shared definitions for the example_4s_preimage enumerator: the sweep FSM
// state type, the size of the input space and the reference truth table.
package ex4s_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of distinct {a,b,c,d} input vectors.
    localparam int EX4S_N_VEC = 16;

    // Reference truth table of the example network, bit i = f(i).
    localparam logic [EX4S_N_VEC-1:0] EX4S_TT = 16'hF90C;

endpackage

// File: rtl/ex4s_eval.sv
// Combinational copy of the 4-input example network, gate for gate:
// t6 = (a^c) & ~(b^d);  f = ((a&b | c&d) & ~t6) | (t6 & ~(c&d)).
module ex4s_eval (
    input  logic [3:0] x,
    output logic       f
);

    logic a, b, c, d;
    logic t1, t2, t3, t4, t5, t6;

    assign {a, b, c, d} = x;

    assign t1 = a & b;
    assign t2 = c & d;
    assign t3 = t1 | t2;
    assign t4 = a ^ c;
    assign t5 = ~(b ^ d);
    assign t6 = t4 & t5;
    assign f  = (t3 & ~t6) | (t6 & ~t2);

endmodule

// File: rtl/example_4s_preimage.sv
// Preimage enumerator for the 4-input example network. On start it sweeps
// idx = 0..15 once, streams every idx with f(idx) == target over a
// valid/ready port (one-entry output register, back-to-back capable) and
// counts the hits. Optional abort port: define EX4S_PREIMAGE_ABORT_EN.
module example_4s_preimage
    import ex4s_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef EX4S_PREIMAGE_ABORT_EN
    input  logic             abort,
`endif
    input  logic             target,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic [3:0]       vec,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam logic [3:0] LAST_IDX = 4'(EX4S_N_VEC - 1);

    state_t     state, state_next;
    logic [3:0] idx;
    logic       tgt;
    logic       f_idx;
    logic       abort_req;
    logic       stall;
    logic       capture, advance, load, clear_valid;

`ifdef EX4S_PREIMAGE_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    ex4s_eval u_eval (
        .x (idx),
        .f (f_idx)
    );

    // The output register is full and the consumer is not taking it.
    assign stall = vec_valid && !vec_ready;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic plus per-cycle datapath controls and status outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through the case can leave one unassigned and infer a latch.
        state_next  = state;
        capture     = 1'b0;
        advance     = 1'b0;
        load        = 1'b0;
        clear_valid = 1'b0;
        busy        = (state != IDLE);
        done        = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (abort_req) begin
                    clear_valid = 1'b1;
                    state_next  = DONE;
                end else if (!stall) begin
                    advance     = 1'b1;
                    load        = (f_idx == tgt);
                    clear_valid = vec_valid && vec_ready;
                    if (idx == LAST_IDX) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (abort_req || !stall) begin
                    clear_valid = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sweep datapath: captured target, index, output register and hit count.
    always_ff @(posedge clk) begin
        // NOTE: the reset here is synchronous; all of these are plain
        // flops, so every one of them is cleared, pending vec included.
        if (rst) begin
            tgt       <= 1'b0;
            idx       <= '0;
            vec       <= '0;
            vec_valid <= 1'b0;
            hit_cnt   <= '0;
        end else begin
            if (capture) begin
                tgt     <= target;
                idx     <= '0;
                hit_cnt <= '0;
            end else if (advance && idx != LAST_IDX) begin
                // idx parks at the last vector; a sweep never wraps.
                idx <= idx + 4'd1;
            end
            if (load) begin
                // A new hit may overwrite an entry accepted this same cycle.
                vec       <= idx;
                vec_valid <= 1'b1;
                hit_cnt   <= hit_cnt + CNT_W'(1);
            end else if (clear_valid) begin
                vec_valid <= 1'b0;
            end
        end
    end

endmodule
